// File: rtl/seq_pkg.sv
// Shared code constants, FSM encoding and code-space helpers for the A/B/C
// sequence generator and its receive-side checker.
package seq_pkg;

    localparam logic [2:0] S0 = 3'b000;
    localparam logic [2:0] S1 = 3'b001;
    localparam logic [2:0] S2 = 3'b010;
    localparam logic [2:0] S3 = 3'b100;
    localparam logic [2:0] S4 = 3'b110;

    localparam logic [2:0] INDEX_ILLEGAL = 3'd7;

    typedef enum logic [1:0] {
        EMPTY,
        ACQUIRE,
        LOCKED
    } seq_state_t;

    // Successor of a legal code; unused codes map to S0 but are never compared.
    function automatic logic [2:0] seq_next(input logic [2:0] code);
        case (code)
            S0:      return S1;
            S1:      return S2;
            S2:      return S3;
            S3:      return S4;
            default: return S0;
        endcase
    endfunction

    function automatic logic seq_legal(input logic [2:0] code);
        case (code)
            S0, S1, S2, S3, S4: return 1'b1;
            default:            return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] seq_index(input logic [2:0] code);
        case (code)
            S0:      return 3'd0;
            S1:      return 3'd1;
            S2:      return 3'd2;
            S3:      return 3'd3;
            S4:      return 3'd4;
            default: return INDEX_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/seq_checker.sv
// Receive-side monitor for the A/B/C sequence generator: acquires lock on the
// legal five-code cycle, then flags deviations and illegal codes.
module seq_checker #(
    parameter int LOCK_COUNT = 3,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    output logic             locked,
    output logic             err,
    output logic             illegal,
    output logic [2:0]       index,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    import seq_pkg::*;

    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_COUNT);

    seq_state_t state_q, state_d;
    logic [3:0] match_q, match_d;
    logic [2:0] prev_q, prev_d;
    logic [2:0] index_d;
    logic [2:0] code;
    logic       hit;
    logic       err_d;
    logic       illegal_d;
    logic       period_inc;

    assign code = {a, b, c};
    assign hit  = (code == seq_next(prev_q));

    always_comb begin
        // NOTE: every target gets a default up front, so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_d    = state_q;
        match_d    = match_q;
        prev_d     = prev_q;
        index_d    = index;
        err_d      = 1'b0;
        illegal_d  = 1'b0;
        period_inc = 1'b0;

        if (in_valid) begin
            if (!seq_legal(code)) begin
                // An unused code always drops back to EMPTY; it is also an error if we were locked.
                illegal_d = 1'b1;
                index_d   = INDEX_ILLEGAL;
                err_d     = (state_q == LOCKED);
                state_d   = EMPTY;
            end else begin
                index_d = seq_index(code);
                prev_d  = code;
                case (state_q)
                    EMPTY: begin
                        state_d = ACQUIRE;
                        match_d = '0;
                    end
                    ACQUIRE: begin
                        if (hit) begin
                            match_d = match_q + 4'd1;
                            if (match_q + 4'd1 == LOCK_TARGET) state_d = LOCKED;
                        end else begin
                            match_d = '0;
                        end
                    end
                    LOCKED: begin
                        if (hit) begin
                            period_inc = (prev_q == S4);
                        end else begin
                            err_d   = 1'b1;
                            state_d = ACQUIRE;
                            match_d = '0;
                        end
                    end
                    default: state_d = EMPTY;
                endcase
            end
        end
    end

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            match_q <= '0;
            prev_q  <= S0;
            locked  <= 1'b0;
            err     <= 1'b0;
            illegal <= 1'b0;
            index   <= 3'd0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
            prev_q  <= prev_d;
            locked  <= (state_d == LOCKED);
            err     <= err_d;
            illegal <= illegal_d;
            index   <= index_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_period_cnt (
        .clk (clk),
        .rst (rst),
        .inc (period_inc),
        .q   (period_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (err_d),
        .q   (err_cnt)
    );

endmodule

// File: doc/seq_checker.md
Name: seq_checker

Overview:
- Receive-side monitor for the team's 3-bit one-hot-style sequence counter (the A/B/C D-flip-flop generator).
- Samples the {A,B,C} code each enabled cycle, acquires lock on the legal cycle, then flags deviations and illegal codes.
- Counts completed periods and errors.
- Sits beside the generator in lab top-levels as its self-check and observability block.

Parameters:
- LOCK_COUNT, 3: consecutive correct transitions required to declare lock (range 1..15).
- CNT_W, 8: width of the period and error counters.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  sample strobe; a, b, c sampled only when high
- a  input  1  code bit 2 (MSB)
- b  input  1  code bit 1
- c  input  1  code bit 0 (LSB)
- locked  output  1  checker is in LOCKED
- err  output  1  one-cycle pulse on a deviation while LOCKED
- illegal  output  1  one-cycle pulse when an unused code is sampled
- index  output  3  position 0..4 of the last legal sample in the cycle; 7 if the last sample was illegal
- period_cnt  output  CNT_W  completed periods while LOCKED, saturating
- err_cnt  output  CNT_W  err pulses since reset, saturating

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. All outputs are registered. Response appears on the clk edge that samples the input; visible in the following cycle.
- Legal cycle (code = {a,b,c}): 000 -> 001 -> 010 -> 100 -> 110 -> 000, with index 0..4.
- Unused codes: 011, 101, 111.
- Reset, when rst=1 at a clk edge:
  - FSM to EMPTY, match counter to 0, prev register to 000.
  - locked=0, err=0, illegal=0, index=0, period_cnt=0, err_cnt=0.
  - Reset applied mid-lock discards everything; the next sample is treated as the first.
- in_valid=0: no state change. err and illegal deassert (pulses only). Counters and locked hold.
- FSM states and transitions:
  - EMPTY: no prior sample. Valid legal sample -> store as prev, go to ACQUIRE with match=0. Valid illegal sample -> illegal pulse, stay in EMPTY.
  - ACQUIRE:
    - Valid sample equal to next(prev) -> match+1. If match reaches LOCK_COUNT, go to LOCKED.
    - Legal but wrong sample -> match=0, stay in ACQUIRE, store prev.
    - Illegal sample -> illegal pulse, go to EMPTY.
    - No err pulse in ACQUIRE.
  - LOCKED:
    - Sample equal to next(prev) -> stay in LOCKED. If the transition is 110 -> 000, period_cnt+1.
    - Any other sample -> err pulse, err_cnt+1, locked drops.
      - Legal sample: go to ACQUIRE, match=0, store prev.
      - Illegal sample: illegal pulse in the same cycle as err, go to EMPTY.
- Repeated sample (same code twice in a row) counts as a mismatch, since in_valid marks a generator clock.
- Counters saturate at 2^CNT_W-1 with no wrap. Saturation of one counter does not affect the other.
- locked=1 exactly when FSM is LOCKED.

Decomposition:
- Shared package `seq_pkg`:
  - Code constants S0=000, S1=001, S2=010, S3=100, S4=110.
  - FSM enum {EMPTY, ACQUIRE, LOCKED}.
  - Function `seq_next(code)` returning the successor of a legal code.
  - Function `seq_legal(code)`.
  - Function `seq_index(code)`.
- Sub-module `sat_counter` (parameter W; ports clk, rst, inc, q), instantiated twice for period_cnt and err_cnt.

Test Plan:
1. Reset, then valid stream 000,001,010,100 (LOCK_COUNT=3) -> locked=0 after the 3rd sample; locked=1 after 100; index=3, err_cnt=0.
2. Locked stream continues 110,000,001 -> period_cnt=1 after 000; further full periods give period_cnt = number of 110->000 transitions; err never asserts.
3. Locked, then sample 010 where 001 is expected -> err=1 for one cycle; err_cnt=1; locked=0. Then 100,110,000 -> relocks; err_cnt stays 1.
4. Locked, then sample 101 -> err=1 and illegal=1 in the same cycle; index=7; FSM to EMPTY; err_cnt=1. Next 000 starts acquisition with no err.
5. Locked, in_valid low for 5 cycles, then next legal code -> locked stays 1; counters unchanged during the gap; no err.
6. With CNT_W=2, force 5 lock/err cycles -> err_cnt saturates at 3. Then rst=1 mid-stream for one clk -> all outputs 0 on the next cycle.
